// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, widths and result-stage types.
package alu_pkg;

    localparam int unsigned RES_W = 4;
    localparam int unsigned FLG_W = 4;

    localparam logic [2:0] OP_INC = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    // FIFO occupancy doubles as the state of the buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [RES_W-1:0] g;
        logic [FLG_W-1:0] flags;
    } res_entry_t;

endpackage

// File: rtl/alu_flag_calc.sv
// Derives {N,Z,C,V} status flags for one ALU result from its opcode and operand signs.
module alu_flag_calc
    import alu_pkg::*;
(
    input  logic [2:0]       in_op,
    input  logic             in_a3,
    input  logic             in_b3,
    input  logic [RES_W-1:0] in_g,
    input  logic             in_cout,
    output logic [FLG_W-1:0] flags
);

    logic y3;

    // y3 is the sign of the operand actually added to A for each arithmetic op
    always_comb begin
        y3    = 1'b0;
        flags = '0;
        case (in_op)
            OP_INC:  y3 = 1'b0;
            OP_ADD:  y3 = in_b3;
            OP_SUB:  y3 = ~in_b3;
            OP_DEC:  y3 = 1'b1;
            default: y3 = 1'b0;
        endcase
        flags[FLG_N] = in_g[RES_W-1];
        flags[FLG_Z] = (in_g == '0);
        if (!in_op[2]) begin
            flags[FLG_C] = in_cout;
            flags[FLG_V] = (in_a3 == y3) && (in_g[RES_W-1] != in_a3);
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag derivation, 2-entry FIFO with valid/ready,
// sticky flags and a popped-result counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_a3,
    input  logic             in_b3,
    input  logic [RES_W-1:0] in_g,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_g,
    output logic [FLG_W-1:0] out_flags,
    output logic [FLG_W-1:0] sticky_flags,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] res_cnt
);

    localparam logic [1:0] OCC_MAX = 2'(DEPTH);

    occ_e             occ_q, occ_d;
    logic             head_q, head_d;
    res_entry_t       ent0_q, ent0_d;
    res_entry_t       ent1_q, ent1_d;
    res_entry_t       out_q, out_d;
    logic [FLG_W-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             push_c, pop_c, tail_c;
    logic [FLG_W-1:0] new_flags_c;
    res_entry_t       new_ent_c;

    alu_flag_calc u_flag_calc (
        .in_op   (in_op),
        .in_a3   (in_a3),
        .in_b3   (in_b3),
        .in_g    (in_g),
        .in_cout (in_cout),
        .flags   (new_flags_c)
    );

    assign push_c    = in_valid && in_ready_q;
    assign pop_c     = out_valid_q && out_ready;
    assign tail_c    = (occ_q == OCC_EMPTY) ? head_q : ~head_q;
    assign new_ent_c = '{g: in_g, flags: new_flags_c};

    // Next-state: FIFO slots, occupancy, sticky flags, counter and the registered head view
    always_comb begin
        occ_d       = occ_q;
        head_d      = head_q;
        ent0_d      = ent0_q;
        ent1_d      = ent1_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;

        if (push_c) begin
            if (tail_c) ent1_d = new_ent_c;
            else        ent0_d = new_ent_c;
        end
        if (pop_c) begin
            head_d = ~head_q;
            cnt_d  = cnt_q + CNT_W'(1);
        end

        case (occ_q)
            OCC_EMPTY: if (push_c) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (push_c && !pop_c)      occ_d = OCC_FULL;
                else if (pop_c && !push_c) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop_c) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase

        // Clear takes effect before the new entry's flags are merged in
        if (sticky_clr) sticky_d = '0;
        if (push_c)     sticky_d = sticky_d | new_flags_c;

        out_d       = head_d ? ent1_d : ent0_d;
        in_ready_d  = (2'(occ_d) != OCC_MAX);
        out_valid_d = (occ_d != OCC_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q       <= OCC_EMPTY;
            head_q      <= 1'b0;
            ent0_q      <= '0;
            ent1_q      <= '0;
            out_q       <= '0;
            sticky_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            head_q      <= head_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            out_q       <= out_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_g        = out_q.g;
    assign out_flags    = out_q.flags;
    assign sticky_flags = sticky_q;
    assign res_cnt      = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic       in_a3;
    logic       in_b3;
    logic [3:0] in_g;
    logic       in_cout;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_g;
    logic [3:0] out_flags;
    logic [3:0] sticky_flags;
    logic       sticky_clr;
    logic [7:0] res_cnt;

    int checks   = 0;
    int failures = 0;

    alu_result_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a3        (in_a3),
        .in_b3        (in_b3),
        .in_g         (in_g),
        .in_cout      (in_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_g        (out_g),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .res_cnt      (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic a3, input logic b3,
                         input logic [3:0] g, input logic cout);
        in_valid = v;
        in_op    = op;
        in_a3    = a3;
        in_b3    = b3;
        in_g     = g;
        in_cout  = cout;
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_g", 32'(out_g), 32'h0);
        chk("rst_out_flags", 32'(out_flags), 32'h0);
        chk("rst_sticky", 32'(sticky_flags), 32'h0);
        chk("rst_res_cnt", 32'(res_cnt), 32'h0);
        chk("rst_in_ready_low", 32'(in_ready), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Add overflow, then sub-to-zero with sticky clear, then logic op masking carry
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 1'b0, 1'b0, 4'b1000, 1'b0);
        tick();
        chk("add_ovf_valid", 32'(out_valid), 32'h1);
        chk("add_ovf_g", 32'(out_g), 32'h8);
        chk("add_ovf_flags", 32'(out_flags), 32'h9);
        chk("add_ovf_sticky", 32'(sticky_flags), 32'h9);
        drive(1'b1, 3'b010, 1'b0, 1'b0, 4'b0000, 1'b1);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sub_zero_g", 32'(out_g), 32'h0);
        chk("sub_zero_flags", 32'(out_flags), 32'h6);
        chk("sub_zero_sticky_clr", 32'(sticky_flags), 32'h6);
        chk("sub_zero_cnt", 32'(res_cnt), 32'h1);
        drive(1'b1, 3'b101, 1'b0, 1'b0, 4'b0000, 1'b1);
        tick();
        chk("or_mask_flags", 32'(out_flags), 32'h4);
        chk("or_mask_sticky", 32'(sticky_flags), 32'h6);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_cnt", 32'(res_cnt), 32'h3);

        // Backpressure: three pushes with consumer stalled
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 1'b0, 1'b0, 4'b0011, 1'b1);
        tick();
        chk("bp_one_in_ready", 32'(in_ready), 32'h1);
        chk("bp_one_g", 32'(out_g), 32'h3);
        chk("bp_one_flags", 32'(out_flags), 32'h0);
        drive(1'b1, 3'b110, 1'b0, 1'b0, 4'b1111, 1'b0);
        tick();
        chk("bp_full_in_ready", 32'(in_ready), 32'h0);
        chk("bp_full_head_g", 32'(out_g), 32'h3);
        drive(1'b1, 3'b111, 1'b0, 1'b0, 4'b0101, 1'b0);
        tick();
        chk("bp_held_in_ready", 32'(in_ready), 32'h0);
        chk("bp_held_valid", 32'(out_valid), 32'h1);
        chk("bp_held_g", 32'(out_g), 32'h3);
        chk("bp_held_cnt", 32'(res_cnt), 32'h3);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_g", 32'(out_g), 32'hF);
        chk("bp_pop1_flags", 32'(out_flags), 32'h8);
        chk("bp_pop1_in_ready", 32'(in_ready), 32'h1);
        chk("bp_pop1_cnt", 32'(res_cnt), 32'h4);
        tick();
        chk("bp_pushpop_g", 32'(out_g), 32'h5);
        chk("bp_pushpop_valid", 32'(out_valid), 32'h1);
        chk("bp_pushpop_cnt", 32'(res_cnt), 32'h5);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        chk("bp_empty_valid", 32'(out_valid), 32'h0);
        chk("bp_empty_cnt", 32'(res_cnt), 32'h6);
        chk("bp_sticky", 32'(sticky_flags), 32'hE);

        // Push+pop at ONE together with sticky clear
        out_ready = 1'b0;
        drive(1'b1, 3'b011, 1'b1, 1'b0, 4'b0111, 1'b1);
        tick();
        chk("dec_ovf_g", 32'(out_g), 32'h7);
        chk("dec_ovf_flags", 32'(out_flags), 32'h3);
        out_ready  = 1'b1;
        sticky_clr = 1'b1;
        drive(1'b1, 3'b001, 1'b1, 1'b1, 4'b1100, 1'b1);
        tick();
        sticky_clr = 1'b0;
        chk("pp_head_g", 32'(out_g), 32'hC);
        chk("pp_head_flags", 32'(out_flags), 32'hA);
        chk("pp_valid", 32'(out_valid), 32'h1);
        chk("pp_in_ready", 32'(in_ready), 32'h1);
        chk("pp_sticky", 32'(sticky_flags), 32'hA);
        chk("pp_cnt", 32'(res_cnt), 32'h7);
        out_ready = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        chk("stall_hold_g", 32'(out_g), 32'hC);
        chk("stall_hold_flags", 32'(out_flags), 32'hA);

        // Fill, then reset mid-stream
        drive(1'b1, 3'b000, 1'b0, 1'b0, 4'b1000, 1'b0);
        tick();
        chk("fill_in_ready", 32'(in_ready), 32'h0);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 4'h0, 1'b0);
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_cnt", 32'(res_cnt), 32'h0);
        chk("mid_rst_sticky", 32'(sticky_flags), 32'h0);
        chk("mid_rst_g", 32'(out_g), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_release_in_ready", 32'(in_ready), 32'h1);
        chk("mid_rst_release_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_release_cnt", 32'(res_cnt), 32'h0);

        // Streaming at full rate: 256 pops wrap the counter back to zero
        drive(1'b1, 3'b110, 1'b0, 1'b0, 4'b0110, 1'b0);
        tick();
        for (int i = 0; i < 255; i++) tick();
        chk("stream_valid", 32'(out_valid), 32'h1);
        chk("stream_in_ready", 32'(in_ready), 32'h1);
        chk("stream_cnt_255", 32'(res_cnt), 32'hFF);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        chk("wrap_cnt_0", 32'(res_cnt), 32'h0);
        chk("wrap_valid", 32'(out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
